// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   Registered ALU control decoder at the ID/EX boundary. Decodes
//   ALUOp/Funct/RT into a 4-bit ALU control word and holds it in a pipeline
//   register. Multiplies occupy the ALU for MUL_CYCLES cycles, and a countdown
//   FSM raises Stall while one is in flight. Undecodable requests pulse
//   Illegal and bump a saturating counter.
// Ports
//   Clk, Rst_n        clock, async active-low reset
//   InValid           decode request this cycle
//   ALUOp/Funct/RT    op class, R-type funct, REGIMM rt select
//   Flush             synchronous kill of in-flight/pending op
//   Ctrl, CtrlValid   registered control word and its valid
//   Stall             upstream must hold (FSM busy with a multiply)
//   Illegal           one-cycle pulse for an undecodable accepted request
//   IllegalCount      saturating count of illegal requests
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [4:0]       RT,
  input  logic             Flush,
  output logic [3:0]       Ctrl,
  output logic             CtrlValid,
  output logic             Stall,
  output logic             Illegal,
  output logic [CNT_W-1:0] IllegalCount
);

  // Countdown needs to hold MUL_CYCLES-1.
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       legal;
    logic       mul;
  } dec_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      ctrl_d;
  logic            cv_d, ill_d;
  logic [CNT_W-1:0] icnt_d;
  dec_t            dec;

  // Pure decode of the request fields.
  always_comb begin
    dec = '{code: 4'b0000, legal: 1'b1, mul: 1'b0};
    case (ALUOp)
      4'd0: begin
        case (Funct)
          6'b100000: dec.code = 4'b0000;
          6'b100010: dec.code = 4'b0001;
          6'b000010: dec.code = 4'b1000;
          6'b100100: dec.code = 4'b0011;
          6'b100101: dec.code = 4'b0100;
          6'b100111: dec.code = 4'b0101;
          6'b101010: dec.code = 4'b1001;
          6'b000000: dec.code = 4'b0111;
          default:   dec.legal = 1'b0;
        endcase
      end
      4'd1:  dec.code = 4'b0000;
      4'd2:  dec.code = 4'b0011;
      4'd3:  dec.code = 4'b0100;
      4'd4:  dec.code = 4'b0110;
      4'd5:  begin dec.code = 4'b0010; dec.mul = 1'b1; end
      4'd7:  dec.code = 4'b1001;
      4'd8:  dec.code = 4'b1010;
      4'd9: begin
        case (RT)
          5'b00000: dec.code = 4'b1110;
          5'b00001: dec.code = 4'b1011;
          default:  dec.legal = 1'b0;
        endcase
      end
      4'd10: dec.code = 4'b1101;
      4'd11: dec.code = 4'b1100;
      4'd12: dec.code = 4'b0001;
      default: dec.legal = 1'b0;
    endcase
  end

  // Next-state / next-output. CtrlValid and Illegal are pulses: default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = Ctrl;
    cv_d    = 1'b0;
    ill_d   = 1'b0;
    icnt_d  = IllegalCount;
    if (Flush) begin
      // Drops any request this cycle; the illegal counter is left alone.
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            if (!dec.legal) begin
              ctrl_d = 4'b0000;
              ill_d  = 1'b1;
              if (IllegalCount != {CNT_W{1'b1}})
                icnt_d = IllegalCount + CNT_W'(1);
            end else if (dec.mul && (MUL_CYCLES > 1)) begin
              ctrl_d  = dec.code;
              cnt_d   = CW'(MUL_CYCLES - 1);
              state_d = BUSY;
            end else begin
              ctrl_d = dec.code;
              cv_d   = 1'b1;
            end
          end
        end
        BUSY: begin
          // Request inputs are ignored; upstream is holding on Stall.
          if (cnt_q != CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            cnt_d   = '0;
            cv_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      Ctrl         <= 4'b0000;
      CtrlValid    <= 1'b0;
      Illegal      <= 1'b0;
      IllegalCount <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      Ctrl         <= ctrl_d;
      CtrlValid    <= cv_d;
      Illegal      <= ill_d;
      IllegalCount <= icnt_d;
    end
  end

  // Registered state only, so no input-to-Stall path.
  assign Stall = (state_q == BUSY);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq. Two instances share stimulus:
// d0 (MUL_CYCLES=4, CNT_W=8) is the main target; d1 (MUL_CYCLES=1, CNT_W=2)
// covers the single-cycle multiply and counter saturation.
module tb_alu_ctrl_seq;
  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       InValid;
  logic [3:0] ALUOp;
  logic [5:0] Funct;
  logic [4:0] RT;
  logic       Flush;

  logic [3:0] ctrl0, ctrl1;
  logic       cv0, cv1, st0, st1, il0, il1;
  logic [7:0] ic0;
  logic [1:0] ic1;

  int total = 0;
  int bad   = 0;

  alu_ctrl_seq #(.MUL_CYCLES(4), .CNT_W(8)) d0 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .ALUOp(ALUOp), .Funct(Funct),
    .RT(RT), .Flush(Flush), .Ctrl(ctrl0), .CtrlValid(cv0), .Stall(st0),
    .Illegal(il0), .IllegalCount(ic0));

  alu_ctrl_seq #(.MUL_CYCLES(1), .CNT_W(2)) d1 (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .ALUOp(ALUOp), .Funct(Funct),
    .RT(RT), .Flush(Flush), .Ctrl(ctrl1), .CtrlValid(cv1), .Stall(st1),
    .Illegal(il1), .IllegalCount(ic1));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [3:0] op, input logic [5:0] fn, input logic [4:0] rt);
    InValid = v; ALUOp = op; Funct = fn; RT = rt;
  endtask

  logic [3:0] vop [6];
  logic [5:0] vfn [6];
  logic [3:0] vexp[6];
  logic [1:0] sat_exp[5];

  initial begin
    vop = '{4'd0, 4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
    vfn = '{6'b100000, 6'b000010, 6'b0, 6'b0, 6'b0, 6'b101010};
    vexp = '{4'b0000, 4'b1000, 4'b0110, 4'b1010, 4'b0001, 4'b1001};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    Rst_n = 1'b0; Flush = 1'b0;
    req(1'b0, 4'd0, 6'd0, 5'd0);
    #12;
    chk("rst_ctrl",  {28'd0, ctrl0}, 32'h0);
    chk("rst_cv",    {31'd0, cv0},   32'h0);
    chk("rst_stall", {31'd0, st0},   32'h0);
    chk("rst_ill",   {31'd0, il0},   32'h0);
    chk("rst_icnt",  {24'd0, ic0},   32'h0);
    tick();
    Rst_n = 1'b1;

    // R-type sub, then an idle cycle.
    req(1'b1, 4'd0, 6'b100010, 5'd0);
    tick();
    chk("sub_ctrl",  {28'd0, ctrl0}, 32'h1);
    chk("sub_cv",    {31'd0, cv0},   32'h1);
    chk("sub_stall", {31'd0, st0},   32'h0);
    req(1'b0, 4'd0, 6'd0, 5'd0);
    tick();
    chk("idle_cv",   {31'd0, cv0},   32'h0);
    chk("idle_hold", {28'd0, ctrl0}, 32'h1);

    // Back-to-back single-cycle requests.
    for (int i = 0; i < 6; i++) begin
      req(1'b1, vop[i], vfn[i], 5'd0);
      tick();
      chk("b2b_ctrl", {28'd0, ctrl0}, {28'd0, vexp[i]});
      chk("b2b_cv",   {31'd0, cv0},   32'h1);
    end

    // REGIMM via RT.
    req(1'b1, 4'd9, 6'd0, 5'b00000);
    tick();
    chk("rt0_ctrl", {28'd0, ctrl0}, 32'hE);
    req(1'b1, 4'd9, 6'd0, 5'b00001);
    tick();
    chk("rt1_ctrl", {28'd0, ctrl0}, 32'hB);
    req(1'b1, 4'd9, 6'd0, 5'b00011);
    tick();
    chk("rt3_ill",  {31'd0, il0},   32'h1);
    chk("rt3_ctrl", {28'd0, ctrl0}, 32'h0);
    chk("rt3_cv",   {31'd0, cv0},   32'h0);
    chk("rt3_icnt", {24'd0, ic0},   32'h1);
    req(1'b0, 4'd0, 6'd0, 5'd0);
    tick();
    chk("ill_pulse", {31'd0, il0}, 32'h0);

    // Multiply, MUL_CYCLES=4 on d0, single cycle on d1.
    req(1'b1, 4'd5, 6'd0, 5'd0);
    tick();                                   // e1
    chk("mul_e1_stall", {31'd0, st0},   32'h1);
    chk("mul_e1_cv",    {31'd0, cv0},   32'h0);
    chk("mul_e1_ctrl",  {28'd0, ctrl0}, 32'h2);
    chk("mul1_cv",      {31'd0, cv1},   32'h1);
    chk("mul1_ctrl",    {28'd0, ctrl1}, 32'h2);
    chk("mul1_stall",   {31'd0, st1},   32'h0);
    req(1'b1, 4'd6, 6'd0, 5'd0);              // must be ignored by d0
    tick();                                   // e2
    chk("mul_e2_stall", {31'd0, st0},   32'h1);
    chk("mul_e2_cv",    {31'd0, cv0},   32'h0);
    chk("mul_e2_ctrl",  {28'd0, ctrl0}, 32'h2);
    tick();                                   // e3
    chk("mul_e3_stall", {31'd0, st0},   32'h1);
    chk("mul_e3_cv",    {31'd0, cv0},   32'h0);
    tick();                                   // e4
    chk("mul_e4_stall", {31'd0, st0},   32'h0);
    chk("mul_e4_cv",    {31'd0, cv0},   32'h1);
    chk("mul_e4_ctrl",  {28'd0, ctrl0}, 32'h2);
    chk("mul_e4_ill",   {31'd0, il0},   32'h0);
    chk("mul_ign_icnt", {24'd0, ic0},   32'h1);
    // New request right after the multiply completes.
    req(1'b1, 4'd1, 6'd0, 5'd0);
    tick();
    chk("post_mul_ctrl", {28'd0, ctrl0}, 32'h0);
    chk("post_mul_cv",   {31'd0, cv0},   32'h1);
    req(1'b0, 4'd0, 6'd0, 5'd0);
    tick();
    chk("post_mul_idle", {31'd0, cv0}, 32'h0);

    // Flush one edge after a multiply is accepted.
    req(1'b1, 4'd5, 6'd0, 5'd0);
    tick();
    chk("fl_busy", {31'd0, st0}, 32'h1);
    req(1'b0, 4'd0, 6'd0, 5'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("fl_stall", {31'd0, st0},   32'h0);
    chk("fl_ctrl",  {28'd0, ctrl0}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("fl_no_cv", {31'd0, cv0}, 32'h0);
      tick();
    end

    // Flush with an illegal request: dropped, not counted.
    req(1'b1, 4'd13, 6'd0, 5'd0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    req(1'b0, 4'd0, 6'd0, 5'd0);
    chk("fl_ill_icnt", {24'd0, ic0}, 32'h1);
    chk("fl_ill_pls",  {31'd0, il0}, 32'h0);

    // Async reset in the middle of a multiply.
    req(1'b1, 4'd5, 6'd0, 5'd0);
    tick();
    req(1'b0, 4'd0, 6'd0, 5'd0);
    chk("ar_busy", {31'd0, st0}, 32'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("ar_stall", {31'd0, st0},   32'h0);
    chk("ar_ctrl",  {28'd0, ctrl0}, 32'h0);
    chk("ar_cv",    {31'd0, cv0},   32'h0);
    chk("ar_icnt",  {24'd0, ic0},   32'h0);
    tick();
    chk("ar_hold_cv", {31'd0, cv0}, 32'h0);
    Rst_n = 1'b1;
    req(1'b1, 4'd0, 6'b100101, 5'd0);
    tick();
    chk("ar_after_ctrl", {28'd0, ctrl0}, 32'h4);
    chk("ar_after_cv",   {31'd0, cv0},   32'h1);

    // Saturation: counts restart from the reset above.
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 4'd6, 6'd0, 5'd0);
      tick();
      chk("sat_icnt2", {30'd0, ic1}, {30'd0, sat_exp[i]});
      chk("sat_icnt8", {24'd0, ic0}, i + 1);
      chk("sat_ill",   {31'd0, il0}, 32'h1);
      chk("sat_cv",    {31'd0, cv0}, 32'h0);
    end
    req(1'b0, 4'd0, 6'd0, 5'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end
endmodule
